// File: rtl/fetch_buffer_if.sv
// Handshake bundle between fetch (master) and the fetch buffer (slave), including flush and occupancy.
interface fetch_buffer_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [2:0]      out_imm_type;
    logic            out_illegal;
    logic [CW-1:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_imm_type, out_illegal, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_imm_type, out_illegal, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction FIFO between fetch and decode; stores a pre-decoded immediate class per entry.
// Optional combinational empty-buffer bypass is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input logic           clk,
    input logic           rst,
    fetch_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_instr [DEPTH];
    logic [2:0]      r_imm   [DEPTH];
    logic            r_ill   [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_in_ready;
    logic            w_push;
    logic            w_write;
    logic            w_pop;
    logic [2:0]      w_in_imm;
    logic            w_in_ill;
    logic            w_out_valid;
    logic [XLEN-1:0] w_out_pc;
    logic [XLEN-1:0] w_out_instr;
    logic [2:0]      w_out_imm;
    logic            w_out_ill;

    function automatic logic [2:0] preDecode(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: preDecode = 3'b000;
            7'b0100011:                                     preDecode = 3'b001;
            7'b1100011:                                     preDecode = 3'b010;
            7'b0110111, 7'b0010111:                         preDecode = 3'b011;
            7'b1101111:                                     preDecode = 3'b100;
            default:                                        preDecode = 3'b111;
        endcase
    endfunction

    assign w_in_imm   = preDecode(bus.in_instr[6:0]);
    assign w_in_ill   = (bus.in_instr[1:0] != 2'b11);
    assign w_in_ready = (r_count != CW'(DEPTH)) && !bus.flush;
    assign w_push     = bus.in_valid && w_in_ready;

    // Outputs are masked to the idle pattern whenever no valid head is presented.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_pc    = '0;
        w_out_instr = '0;
        w_out_imm   = 3'b111;
        w_out_ill   = 1'b0;
        w_write     = w_push;
        w_pop       = 1'b0;
        if (!bus.flush) begin
            if (r_count != '0) begin
                w_out_valid = 1'b1;
                w_out_pc    = r_pc[r_rptr];
                w_out_instr = r_instr[r_rptr];
                w_out_imm   = r_imm[r_rptr];
                w_out_ill   = r_ill[r_rptr];
                w_pop       = bus.out_ready;
            end
`ifdef FETCH_BUF_BYPASS_EN
            else if (bus.in_valid) begin
                w_out_valid = 1'b1;
                w_out_pc    = bus.in_pc;
                w_out_instr = bus.in_instr;
                w_out_imm   = w_in_imm;
                w_out_ill   = w_in_ill;
                w_write     = w_push && !bus.out_ready;
            end
`endif
        end
    end

    // Flush wins over push/pop; storage is left alone and masked by count==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
                r_imm[i]   <= '0;
                r_ill[i]   <= 1'b0;
            end
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_pc[r_wptr]    <= bus.in_pc;
                r_instr[r_wptr] <= bus.in_instr;
                r_imm[r_wptr]   <= w_in_imm;
                r_ill[r_wptr]   <= w_in_ill;
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_write) - CW'(w_pop);
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_pc       = w_out_pc;
    assign bus.out_instr    = w_out_instr;
    assign bus.out_imm_type = w_out_imm;
    assign bus.out_illegal  = w_out_ill;
    assign bus.count        = r_count;
endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model (default build, no bypass).
module tb_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct {
        logic        flush;
        logic        inValid;
        logic        outReady;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        expOutValid;
        logic        expInReady;
        logic [2:0]  expCount;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [2:0]  expImm;
        logic        expIll;
        logic        checkData;
    } vecT;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entryT;

    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;
    vecT  vecs[$];
    entryT refQ[$];

    fetch_buffer_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] refImm(input logic [31:0] instr);
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return 3'b000;
            7'b0100011:                                     return 3'b001;
            7'b1100011:                                     return 3'b010;
            7'b0110111, 7'b0010111:                         return 3'b011;
            7'b1101111:                                     return 3'b100;
            default:                                        return 3'b111;
        endcase
    endfunction

    function automatic void addVec(input logic f, iv, ordy, input logic [31:0] pc, instr,
                                   input logic eov, eir, input logic [2:0] ecnt,
                                   input logic [31:0] epc, einstr, input logic [2:0] eimm,
                                   input logic eill, chk);
        vecT v;
        v.flush = f; v.inValid = iv; v.outReady = ordy; v.pc = pc; v.instr = instr;
        v.expOutValid = eov; v.expInReady = eir; v.expCount = ecnt; v.expPc = epc;
        v.expInstr = einstr; v.expImm = eimm; v.expIll = eill; v.checkData = chk;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic f, iv, ordy, input logic [31:0] pc, instr);
        bus.flush     = f;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.in_pc     = pc;
        bus.in_instr  = instr;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, ".count"}, 64'(bus.count), 64'd0);
        checkOutput({tag, ".out_pc"}, 64'(bus.out_pc), 64'd0);
        checkOutput({tag, ".out_instr"}, 64'(bus.out_instr), 64'd0);
        checkOutput({tag, ".out_imm_type"}, 64'(bus.out_imm_type), 64'd7);
        checkOutput({tag, ".out_illegal"}, 64'(bus.out_illegal), 64'd0);
    endtask

    // One cycle against the queue model: check pre-edge outputs, then advance the model.
    task automatic modelStep(input string tag, input logic f, iv, ordy, input logic [31:0] pc, instr);
        logic  expOv, expIr, doPush, doPop;
        entryT e;
        int    n;
        applyStimulus(f, iv, ordy, pc, instr);
        #3;
        n     = refQ.size();
        expIr = (n != DEPTH) && !f;
        expOv = (n != 0) && !f;
        checkOutput({tag, ".in_ready"}, 64'(bus.in_ready), 64'(expIr));
        checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'(expOv));
        checkOutput({tag, ".count"}, 64'(bus.count), 64'(n));
        if (expOv) begin
            checkOutput({tag, ".out_pc"}, 64'(bus.out_pc), 64'(refQ[0].pc));
            checkOutput({tag, ".out_instr"}, 64'(bus.out_instr), 64'(refQ[0].instr));
            checkOutput({tag, ".out_imm_type"}, 64'(bus.out_imm_type), 64'(refImm(refQ[0].instr)));
            checkOutput({tag, ".out_illegal"}, 64'(bus.out_illegal), 64'(refQ[0].instr[1:0] != 2'b11));
        end else if (!f) begin
            checkOutput({tag, ".out_pc"}, 64'(bus.out_pc), 64'd0);
            checkOutput({tag, ".out_imm_type"}, 64'(bus.out_imm_type), 64'd7);
            checkOutput({tag, ".out_illegal"}, 64'(bus.out_illegal), 64'd0);
        end
        doPush = iv && expIr;
        doPop  = expOv && ordy;
        @(posedge clk);
        #1;
        if (f) begin
            refQ.delete();
        end else begin
            if (doPop) void'(refQ.pop_front());
            if (doPush) begin
                e.pc = pc;
                e.instr = instr;
                refQ.push_back(e);
            end
        end
    endtask

    initial begin
        logic [6:0]  ops [11];
        logic [6:0]  op;
        logic [31:0] rnd;
        int          sel;

        vecCount  = 0;
        missCount = 0;
        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0000000};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        checkIdle("reset_held");
        rst = 1'b0;
        @(posedge clk);
        #1;

        //      f  iv or  pc         instr         ov ir cnt pc         instr         imm   ill chk
        addVec(0, 0, 0, 32'h0,     32'h0,        0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 1, 0, 32'h100,   32'h00500093, 0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 0, 0, 32'h0,     32'h0,        1, 1, 1, 32'h100,   32'h00500093, 3'd0, 0, 1);
        addVec(0, 0, 1, 32'h0,     32'h0,        1, 1, 1, 32'h100,   32'h00500093, 3'd0, 0, 1);
        addVec(0, 1, 0, 32'h104,   32'h00112023, 0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 1, 0, 32'h108,   32'h00000463, 1, 1, 1, 32'h104,   32'h00112023, 3'd1, 0, 1);
        addVec(0, 1, 0, 32'h10c,   32'h123450b7, 1, 1, 2, 32'h104,   32'h00112023, 3'd1, 0, 1);
        addVec(0, 1, 0, 32'h110,   32'h008000ef, 1, 1, 3, 32'h104,   32'h00112023, 3'd1, 0, 1);
        addVec(0, 1, 0, 32'h114,   32'h00000013, 1, 0, 4, 32'h104,   32'h00112023, 3'd1, 0, 1);
        addVec(0, 1, 1, 32'h114,   32'h00000013, 1, 0, 4, 32'h104,   32'h00112023, 3'd1, 0, 1);
        addVec(0, 1, 1, 32'h114,   32'h00000013, 1, 1, 3, 32'h108,   32'h00000463, 3'd2, 0, 1);
        addVec(0, 0, 1, 32'h0,     32'h0,        1, 1, 3, 32'h10c,   32'h123450b7, 3'd3, 0, 1);
        addVec(0, 0, 1, 32'h0,     32'h0,        1, 1, 2, 32'h110,   32'h008000ef, 3'd4, 0, 1);
        addVec(0, 0, 1, 32'h0,     32'h0,        1, 1, 1, 32'h114,   32'h00000013, 3'd0, 0, 1);
        addVec(0, 0, 0, 32'h0,     32'h0,        0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 1, 0, 32'h200,   32'h00000013, 0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 1, 0, 32'h204,   32'h00000033, 1, 1, 1, 32'h200,   32'h00000013, 3'd0, 0, 1);
        addVec(0, 1, 0, 32'h208,   32'h00000013, 1, 1, 2, 32'h200,   32'h00000013, 3'd0, 0, 1);
        addVec(1, 1, 1, 32'h20c,   32'h00000013, 0, 0, 3, 32'h0,     32'h0,        3'd7, 0, 0);
        addVec(0, 0, 0, 32'h0,     32'h0,        0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 1, 0, 32'h300,   32'h00000033, 0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 0, 0, 32'h0,     32'h0,        1, 1, 1, 32'h300,   32'h00000033, 3'd7, 0, 1);
        addVec(0, 0, 1, 32'h0,     32'h0,        1, 1, 1, 32'h300,   32'h00000033, 3'd7, 0, 1);
        addVec(0, 1, 0, 32'h304,   32'h00000000, 0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);
        addVec(0, 0, 0, 32'h0,     32'h0,        1, 1, 1, 32'h304,   32'h00000000, 3'd7, 1, 1);
        addVec(0, 0, 1, 32'h0,     32'h0,        1, 1, 1, 32'h304,   32'h00000000, 3'd7, 1, 1);
        addVec(0, 0, 0, 32'h0,     32'h0,        0, 1, 0, 32'h0,     32'h0,        3'd7, 0, 1);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].flush, vecs[i].inValid, vecs[i].outReady, vecs[i].pc, vecs[i].instr);
            #3;
            checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'(vecs[i].expOutValid));
            checkOutput({tag, ".in_ready"}, 64'(bus.in_ready), 64'(vecs[i].expInReady));
            checkOutput({tag, ".count"}, 64'(bus.count), 64'(vecs[i].expCount));
            if (vecs[i].checkData) begin
                checkOutput({tag, ".out_pc"}, 64'(bus.out_pc), 64'(vecs[i].expPc));
                checkOutput({tag, ".out_instr"}, 64'(bus.out_instr), 64'(vecs[i].expInstr));
                checkOutput({tag, ".out_imm_type"}, 64'(bus.out_imm_type), 64'(vecs[i].expImm));
                checkOutput({tag, ".out_illegal"}, 64'(bus.out_illegal), 64'(vecs[i].expIll));
            end
            @(posedge clk);
            #1;
        end

        // Steady push+pop at occupancy 2; twelve pushes wrap the pointers several times.
        refQ.delete();
        modelStep("steady_fill", 1'b0, 1'b1, 1'b0, 32'h400, 32'h00000013);
        modelStep("steady_fill", 1'b0, 1'b1, 1'b0, 32'h404, 32'h00112023);
        for (int i = 0; i < 10; i++) begin
            modelStep($sformatf("steady%0d", i), 1'b0, 1'b1, 1'b1, 32'h408 + 32'(4 * i),
                      {25'(i), ops[i % 11]});
            checkOutput($sformatf("steady%0d.occupancy", i), 64'(bus.count), 64'd2);
        end

        // Asynchronous reset mid-drain must clear outputs before the next clock edge.
        modelStep("async_fill", 1'b0, 1'b1, 1'b1, 32'h500, 32'h00500093);
        modelStep("async_fill", 1'b0, 1'b1, 1'b0, 32'h504, 32'h00000463);
        modelStep("async_drain", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        checkIdle("async_rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        refQ.delete();
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 13);
            rnd = $urandom;
            op  = (sel < 11) ? ops[sel] : rnd[6:0];
            modelStep($sformatf("rand%0d", i), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 1) == 1), $urandom & 32'hffff_fffc, {rnd[31:7], op});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction FIFO between the fetch stage and the decode stage. Decode contains the immediate generator.
- Buffers fetched {pc, instr} pairs with a valid/ready handshake on both sides.
- Pre-decodes the opcode into the 3-bit imm_type code that decode's immediate generator consumes. The code is stored per entry, so decode gets it with no opcode logic of its own.
- A redirect flush discards all buffered instructions on a taken branch, jump or trap.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, width of pc and instr.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  redirect; discards all entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  buffer accepts it this cycle.
- in_pc  input  XLEN  pc of the incoming instruction.
- in_instr  input  XLEN  raw incoming instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head.
- out_pc  output  XLEN  head pc.
- out_instr  output  XLEN  head instruction.
- out_imm_type  output  3  pre-decoded immediate class of the head.
- out_illegal  output  1  head has instr[1:0] != 2'b11 (not a 32-bit encoding).
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, active-high; clk and rst naming fixed as in the codebase):
  - Pointers and count clear to 0; all entry storage clears to 0.
  - Outputs during and after reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0, out_imm_type=3'b111, out_illegal=0.
  - Reset asserted mid-operation drops all contents immediately, without waiting for a clock edge.
- Handshakes:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - in_ready = (count != DEPTH) && !flush. It has no combinational dependence on out_ready.
  - out_valid = (count != 0) && !flush.
- Latency:
  - Minimum 1 cycle: an entry pushed at edge N is visible on out_* in the cycle after edge N.
  - Throughput is one instruction per cycle in steady state.
- Simultaneous push and pop, with the buffer neither empty nor full: both occur and count is unchanged.
- Full with out_ready=1: in_ready stays 0 that cycle. The pop frees a slot and the next push is accepted the following cycle.
- Empty: out_valid=0. out_pc/out_instr are 0, out_imm_type is 3'b111 and out_illegal is 0; the outputs are masked, not stale.
- Flush:
  - Highest priority. In the flush cycle, no push and no pop take effect.
  - At the next edge, read/write pointers and count go to 0.
  - Entry storage is not cleared; it is masked by count==0.
- Pointers are log2(DEPTH) bits wide and wrap naturally modulo DEPTH. Full/empty are determined by count, never by pointer compare.
- Pre-decode is computed on in_instr[6:0] at push time and stored with the entry:
  - 0000011, 0010011, 1100111, 1110011 -> 3'b000 (I).
  - 0100011 -> 3'b001 (S).
  - 1100011 -> 3'b010 (B).
  - 0110111, 0010111 -> 3'b011 (U).
  - 1101111 -> 3'b100 (J).
  - All others, including R-type 0110011 -> 3'b111 (no immediate; the immediate generator outputs 0).
- out_illegal is stored per entry at push time: in_instr[1:0] != 2'b11.
- Out-of-range states are not reachable: count never exceeds DEPTH.

Optional Feature:
- Macro FETCH_BUF_BYPASS_EN.
- Defined: when count==0 and !flush, in_* passes combinationally to out_*.
  - out_valid = in_valid in that case, with the pre-decode computed on the fly.
  - If out_ready=1, the instruction is consumed with zero latency and is not written to storage.
  - If out_ready=0, it is written normally.
  - In this mode in_ready is still independent of out_ready.
- Undefined: no bypass; minimum latency is exactly 1 cycle as above.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, out_imm_type=3'b111.
- Push pc=0x100 instr=0x00500093 (addi) -> next cycle out_valid=1, out_pc=0x100, out_imm_type=3'b000, out_illegal=0.
- Push 4 instructions with out_ready=0:
  - sw 0x00112023, beq 0x00000463, lui 0x123450b7, jal 0x008000ef.
  - -> count=4, in_ready=0.
  - Then drain with out_ready=1 -> out_imm_type sequence 001,010,011,100 in order; count reaches 0.
- Full buffer with push and pop asserted in the same cycle -> pop accepted, push rejected, count=3. Steady push+pop at count=2 for 10 cycles -> count stays 2 and pointers wrap correctly.
- Buffer holding 3 entries, flush=1 with in_valid=1 -> no push; next cycle count=0 and out_valid=0. Push 0x00000033 afterwards -> out_imm_type=3'b111.
- Push instr=0x00000000 -> out_illegal=1. Assert rst asynchronously mid-drain -> outputs return to reset values before the next clk edge.
